// File: rtl/i2c_slave_ctrl.sv
// i2c_slave_ctrl: I2C target controller for one fixed 7-bit address.
// SCL/SDA are oversampled by the system clock. Received bytes are presented on
// the shared data bus with a one-cycle writeOK strobe. Bytes to transmit are
// loaded from the data bus by data_in. SCL is input-only, so there is no clock stretching.
module i2c_slave_ctrl #(
    parameter logic [6:0] i2c_slave_addr = 7'h49
) (
    input  logic       clock,
    input  logic       reset,
    inout  wire        SDA,
    input  logic       SCL,
    inout  wire  [7:0] data,
    output logic       writeOK,
    input  logic       data_in
);

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        RX,
        RX_ACK,
        TX,
        TX_ACK,
        WAIT_STOP
    } state_t;

    state_t     state_q;
    logic       scl_s_q, scl_p_q, sda_s_q, sda_p_q;
    logic [3:0] bitcnt_q;
    logic [7:0] shift_q;
    logic [7:0] data_q;
    logic [7:0] hold_q;
    logic       dir_q;
    logic       ack_q;
    logic       sda_oe_q;
    logic       data_oe_q;
    logic       writeok_q;

    logic       scl_rise, scl_fall, bus_start, bus_stop, read_state;
    logic [7:0] tx_next;

    assign scl_rise   = scl_s_q & ~scl_p_q;
    assign scl_fall   = ~scl_s_q & scl_p_q;
    assign bus_start  = scl_s_q & scl_p_q & sda_p_q & ~sda_s_q;
    assign bus_stop   = scl_s_q & scl_p_q & ~sda_p_q & sda_s_q;
    assign read_state = dir_q && (state_q inside {ADDR_ACK, TX, TX_ACK});
    // A data_in in the same cycle that a byte starts must win over the stale holding value.
    assign tx_next    = (read_state && data_in) ? data : hold_q;

    assign SDA     = sda_oe_q ? 1'b0 : 1'bz;
    assign data    = data_oe_q ? data_q : 'z;
    assign writeOK = writeok_q;

    // Register the bus lines once per clock and keep the previous sample for edge detection.
    always_ff @(posedge clock) begin
        if (reset) begin
            scl_s_q <= 1'b1;
            scl_p_q <= 1'b1;
            sda_s_q <= 1'b1;
            sda_p_q <= 1'b1;
        end else begin
            scl_s_q <= SCL;
            scl_p_q <= scl_s_q;
            sda_s_q <= SDA;
            sda_p_q <= sda_s_q;
        end
    end

    // Protocol FSM with registered SDA/data enables and the writeOK strobe.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            bitcnt_q  <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            hold_q    <= '1;
            dir_q     <= 1'b0;
            ack_q     <= 1'b0;
            sda_oe_q  <= 1'b0;
            data_oe_q <= 1'b0;
            writeok_q <= 1'b0;
        end else begin
            writeok_q <= 1'b0;
            if (read_state && data_in) begin
                hold_q <= data;
            end
            if (bus_start) begin
                state_q   <= ADDR;
                bitcnt_q  <= '0;
                ack_q     <= 1'b0;
                sda_oe_q  <= 1'b0;
                data_oe_q <= 1'b0;
            end else if (bus_stop) begin
                state_q  <= IDLE;
                ack_q    <= 1'b0;
                sda_oe_q <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: ;
                    ADDR: begin
                        if (scl_rise) begin
                            shift_q  <= {shift_q[6:0], sda_s_q};
                            bitcnt_q <= bitcnt_q + 4'd1;
                            if (bitcnt_q == 4'd7) begin
                                if (shift_q[6:0] == i2c_slave_addr) begin
                                    state_q   <= ADDR_ACK;
                                    dir_q     <= sda_s_q;
                                    data_oe_q <= ~sda_s_q;
                                    ack_q     <= 1'b0;
                                end else begin
                                    state_q <= WAIT_STOP;
                                end
                            end
                        end
                    end
                    // ack_q marks that SDA is being held low for the ACK slot.
                    ADDR_ACK, RX_ACK: begin
                        if (scl_fall) begin
                            if (!ack_q) begin
                                sda_oe_q <= 1'b1;
                                ack_q    <= 1'b1;
                            end else begin
                                ack_q    <= 1'b0;
                                bitcnt_q <= '0;
                                if (state_q == RX_ACK || !dir_q) begin
                                    sda_oe_q <= 1'b0;
                                    state_q  <= RX;
                                end else begin
                                    shift_q  <= tx_next;
                                    sda_oe_q <= ~tx_next[7];
                                    bitcnt_q <= 4'd1;
                                    state_q  <= TX;
                                end
                            end
                        end
                    end
                    RX: begin
                        if (scl_rise) begin
                            shift_q  <= {shift_q[6:0], sda_s_q};
                            bitcnt_q <= bitcnt_q + 4'd1;
                            if (bitcnt_q == 4'd7) begin
                                data_q    <= {shift_q[6:0], sda_s_q};
                                writeok_q <= 1'b1;
                                ack_q     <= 1'b0;
                                state_q   <= RX_ACK;
                            end
                        end
                    end
                    TX: begin
                        if (scl_fall) begin
                            if (bitcnt_q == 4'd8) begin
                                sda_oe_q <= 1'b0;
                                ack_q    <= 1'b0;
                                state_q  <= TX_ACK;
                            end else begin
                                shift_q  <= {shift_q[6:0], 1'b0};
                                sda_oe_q <= ~shift_q[6];
                                bitcnt_q <= bitcnt_q + 4'd1;
                            end
                        end
                    end
                    // ack_q here records that the master acknowledged the previous byte.
                    TX_ACK: begin
                        if (scl_rise) begin
                            if (sda_s_q) begin
                                state_q <= WAIT_STOP;
                            end else begin
                                ack_q <= 1'b1;
                            end
                        end else if (scl_fall && ack_q) begin
                            ack_q    <= 1'b0;
                            shift_q  <= tx_next;
                            sda_oe_q <= ~tx_next[7];
                            bitcnt_q <= 4'd1;
                            state_q  <= TX;
                        end
                    end
                    WAIT_STOP: begin
                        sda_oe_q <= 1'b0;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_slave_ctrl.sv
// Testbench for i2c_slave_ctrl: a bit-level I2C master plus a downstream model,
// checked against transaction-level expectations (ACK slots, byte streams, held TX byte).
module tb_i2c_slave_ctrl;

    logic       clock = 1'b0;
    logic       reset;
    logic       scl_m;
    logic       sda_m_low;
    logic       dn_drive;
    logic [7:0] dn_data;
    logic       data_in;
    logic       writeOK;
    tri1        SDA;
    tri1  [7:0] data;

    assign SDA  = sda_m_low ? 1'b0 : 1'bz;
    assign data = dn_drive ? dn_data : 8'hzz;

    always #5 clock = ~clock;

    i2c_slave_ctrl #(.i2c_slave_addr(7'h49)) dut (
        .clock   (clock),
        .reset   (reset),
        .SDA     (SDA),
        .SCL     (scl_m),
        .data    (data),
        .writeOK (writeOK),
        .data_in (data_in)
    );

    int         tests_run    = 0;
    int         tests_failed = 0;
    int         wok_cycles   = 0;
    int         slave_low    = 0;
    logic [7:0] wok_q[$];
    logic [7:0] hold_model;

    // Observers sampled away from the active edge.
    always @(negedge clock) begin
        if (writeOK === 1'b1) begin
            wok_cycles++;
            wok_q.push_back(data);
        end
        if (!sda_m_low && SDA !== 1'b1) slave_low++;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    // One SCL period starting just after a falling edge: SDA set 4 clocks in, SCL high 8 clocks.
    task automatic bit_cycle(input logic b, output logic seen);
        tick(4);
        sda_m_low = ~b;
        tick(8);
        scl_m = 1'b1;
        tick(4);
        seen = SDA;
        tick(4);
        scl_m = 1'b0;
    endtask

    task automatic send_start();
        sda_m_low = 1'b0;
        tick(4);
        scl_m = 1'b1;
        tick(6);
        sda_m_low = 1'b1;
        tick(6);
        scl_m = 1'b0;
    endtask

    task automatic send_stop();
        tick(4);
        sda_m_low = 1'b1;
        tick(8);
        scl_m = 1'b1;
        tick(6);
        sda_m_low = 1'b0;
        tick(6);
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) bit_cycle(b[i], s);
        bit_cycle(1'b1, ack);
    endtask

    task automatic pulse_load(input logic [7:0] v);
        dn_data  = v;
        dn_drive = 1'b1;
        data_in  = 1'b1;
        tick(1);
        data_in  = 1'b0;
        dn_drive = 1'b0;
    endtask

    task automatic master_write(input logic [6:0] addr, input int n, input logic [7:0] pl[8],
                                output logic acks[9], output logic [7:0] dat[8]);
        logic a;
        for (int k = 0; k < 8; k++) dat[k] = 8'h00;
        send_start();
        send_byte({addr, 1'b0}, a);
        acks[0] = a;
        for (int k = 0; k < n; k++) begin
            send_byte(pl[k], a);
            acks[k+1] = a;
            tick(2);
            dat[k] = data;
        end
    endtask

    task automatic master_read(input logic [6:0] addr, input int n, input logic ld_en[8],
                               input logic [7:0] ld_val[8], output logic aack,
                               output logic [7:0] got[8], output logic rel, output logic [7:0] bus_mid);
        logic s;
        logic [7:0] ab;
        ab = {addr, 1'b1};
        for (int k = 0; k < 8; k++) got[k] = 8'h00;
        send_start();
        for (int i = 7; i >= 0; i--) bit_cycle(ab[i], s);
        if (ld_en[0]) pulse_load(ld_val[0]);
        bit_cycle(1'b1, aack);
        bus_mid = data;
        for (int k = 0; k < n; k++) begin
            for (int i = 7; i >= 0; i--) begin
                bit_cycle(1'b1, s);
                got[k][i] = s;
            end
            if (k < n - 1 && ld_en[k+1]) pulse_load(ld_val[k+1]);
            bit_cycle(k == n - 1, s);
        end
        tick(3);
        rel = SDA;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        scl_m = 1'b1;
        sda_m_low = 1'b0;
        dn_drive = 1'b0;
        dn_data = 8'h00;
        data_in = 1'b0;
        tick(4);
        tests_run++;
        if (writeOK !== 1'b0) begin tests_failed++; $display("FAIL reset_writeOK: got %b expected 0", writeOK); end
        tests_run++;
        if (SDA !== 1'b1) begin tests_failed++; $display("FAIL reset_sda: got %b expected released(1)", SDA); end
        tests_run++;
        if (data !== 8'hFF) begin tests_failed++; $display("FAIL reset_data: got %h expected released(ff)", data); end
        reset = 1'b0;
        hold_model = 8'hFF;
        tick(6);
        tests_run++;
        if (SDA !== 1'b1 || writeOK !== 1'b0) begin
            tests_failed++; $display("FAIL post_reset_idle: sda=%b writeOK=%b expected 1/0", SDA, writeOK);
        end
    endtask

    task automatic test_single_write();
        logic [7:0] pl[8] = '{8'hA5, 0, 0, 0, 0, 0, 0, 0};
        logic acks[9];
        logic [7:0] dat[8];
        int w0;
        w0 = wok_cycles;
        wok_q.delete();
        master_write(7'h49, 1, pl, acks, dat);
        send_stop();
        tick(20);
        tests_run++;
        if (acks[0] !== 1'b0) begin tests_failed++; $display("FAIL single_addr_ack: got %b expected 0", acks[0]); end
        tests_run++;
        if (acks[1] !== 1'b0) begin tests_failed++; $display("FAIL single_data_ack: got %b expected 0", acks[1]); end
        tests_run++;
        if (wok_cycles - w0 != 1) begin tests_failed++; $display("FAIL single_writeOK_cycles: got %0d expected 1", wok_cycles - w0); end
        tests_run++;
        if (dat[0] !== 8'hA5) begin tests_failed++; $display("FAIL single_data: got %h expected a5", dat[0]); end
        tests_run++;
        if (SDA !== 1'b1 || writeOK !== 1'b0 || data !== 8'hA5) begin
            tests_failed++; $display("FAIL single_idle_after: sda=%b writeOK=%b data=%h expected 1/0/a5", SDA, writeOK, data);
        end
    endtask

    task automatic test_multi_write();
        logic [7:0] pl[8] = '{8'h01, 8'hFF, 8'h00, 8'h5A, 0, 0, 0, 0};
        logic acks[9];
        logic [7:0] dat[8];
        int w0;
        w0 = wok_cycles;
        wok_q.delete();
        master_write(7'h49, 4, pl, acks, dat);
        send_stop();
        for (int k = 0; k < 5; k++) begin
            tests_run++;
            if (acks[k] !== 1'b0) begin tests_failed++; $display("FAIL multi_ack[%0d]: got %b expected 0", k, acks[k]); end
        end
        for (int k = 0; k < 4; k++) begin
            tests_run++;
            if (dat[k] !== pl[k]) begin tests_failed++; $display("FAIL multi_data[%0d]: got %h expected %h", k, dat[k], pl[k]); end
        end
        tests_run++;
        if (wok_cycles - w0 != 4 || wok_q.size() != 4) begin
            tests_failed++; $display("FAIL multi_writeOK: cycles %0d bytes %0d expected 4/4", wok_cycles - w0, wok_q.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                tests_run++;
                if (wok_q[k] !== pl[k]) begin tests_failed++; $display("FAIL multi_strobe_byte[%0d]: got %h expected %h", k, wok_q[k], pl[k]); end
            end
        end
    endtask

    task automatic test_addr_mismatch();
        logic [7:0] pl[8] = '{8'h77, 0, 0, 0, 0, 0, 0, 0};
        logic acks[9];
        logic [7:0] dat[8];
        int w0, l0;
        w0 = wok_cycles;
        l0 = slave_low;
        master_write(7'h22, 1, pl, acks, dat);
        send_stop();
        tests_run++;
        if (acks[0] !== 1'b1 || acks[1] !== 1'b1) begin
            tests_failed++; $display("FAIL mismatch_ack: got %b/%b expected 1/1 (no ack)", acks[0], acks[1]);
        end
        tests_run++;
        if (slave_low != l0) begin tests_failed++; $display("FAIL mismatch_sda_driven: %0d low cycles expected 0", slave_low - l0); end
        tests_run++;
        if (wok_cycles != w0) begin tests_failed++; $display("FAIL mismatch_writeOK: %0d cycles expected 0", wok_cycles - w0); end
        tests_run++;
        if (dat[0] !== 8'hFF || data !== 8'hFF) begin
            tests_failed++; $display("FAIL mismatch_data_z: got %h/%h expected released(ff)", dat[0], data);
        end
    endtask

    // Reads are checked against a model of the holding register: each byte is the
    // last value loaded by data_in before that byte started, 8'hFF since reset.
    task automatic run_read(input string name, input int n, input logic ld_en[8], input logic [7:0] ld_val[8]);
        logic [7:0] expv[8];
        logic [7:0] got[8];
        logic aack, rel;
        logic [7:0] bus_mid;
        int w0;
        for (int k = 0; k < n; k++) begin
            if (ld_en[k]) hold_model = ld_val[k];
            expv[k] = hold_model;
        end
        w0 = wok_cycles;
        master_read(7'h49, n, ld_en, ld_val, aack, got, rel, bus_mid);
        send_stop();
        tests_run++;
        if (aack !== 1'b0) begin tests_failed++; $display("FAIL %s addr_ack: got %b expected 0", name, aack); end
        for (int k = 0; k < n; k++) begin
            tests_run++;
            if (got[k] !== expv[k]) begin tests_failed++; $display("FAIL %s byte[%0d]: got %h expected %h", name, k, got[k], expv[k]); end
        end
        tests_run++;
        if (rel !== 1'b1) begin tests_failed++; $display("FAIL %s release_after_nack: got %b expected 1", name, rel); end
        tests_run++;
        if (wok_cycles != w0 || bus_mid !== 8'hFF) begin
            tests_failed++; $display("FAIL %s read_side_effects: writeOK cycles %0d data %h expected 0/ff", name, wok_cycles - w0, bus_mid);
        end
    endtask

    task automatic test_read_single();
        logic en[8] = '{1, 0, 0, 0, 0, 0, 0, 0};
        logic [7:0] v[8] = '{8'h3C, 0, 0, 0, 0, 0, 0, 0};
        run_read("read_3c", 1, en, v);
    endtask

    task automatic test_read_two();
        logic en[8] = '{1, 1, 0, 0, 0, 0, 0, 0};
        logic [7:0] v[8] = '{8'h81, 8'h7E, 0, 0, 0, 0, 0, 0};
        run_read("read_81_7e", 2, en, v);
    endtask

    task automatic test_reset_midway();
        logic [7:0] pl[8] = '{8'hC3, 0, 0, 0, 0, 0, 0, 0};
        logic [7:0] junk;
        logic acks[9];
        logic [7:0] dat[8];
        logic a, s;
        int w0;
        junk = 8'hF0;
        w0 = wok_cycles;
        send_start();
        send_byte({7'h49, 1'b0}, a);
        tests_run++;
        if (a !== 1'b0) begin tests_failed++; $display("FAIL abort_addr_ack: got %b expected 0", a); end
        for (int i = 7; i >= 4; i--) bit_cycle(junk[i], s);
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        hold_model = 8'hFF;
        for (int i = 3; i >= 0; i--) bit_cycle(junk[i], s);
        bit_cycle(1'b1, a);
        tests_run++;
        if (a !== 1'b1) begin tests_failed++; $display("FAIL abort_no_ack: got %b expected 1", a); end
        send_stop();
        tests_run++;
        if (wok_cycles != w0) begin tests_failed++; $display("FAIL abort_writeOK: %0d cycles expected 0", wok_cycles - w0); end
        master_write(7'h49, 1, pl, acks, dat);
        send_stop();
        tests_run++;
        if (acks[0] !== 1'b0 || acks[1] !== 1'b0) begin
            tests_failed++; $display("FAIL after_abort_acks: got %b/%b expected 0/0", acks[0], acks[1]);
        end
        tests_run++;
        if (dat[0] !== 8'hC3 || wok_cycles - w0 != 1) begin
            tests_failed++; $display("FAIL after_abort_data: got %h cycles %0d expected c3/1", dat[0], wok_cycles - w0);
        end
    endtask

    task automatic test_random_reads();
        logic en[8];
        logic [7:0] v[8];
        int n;
        for (int it = 0; it < 4; it++) begin
            n = $urandom_range(1, 3);
            for (int k = 0; k < 8; k++) begin
                en[k] = 1'($urandom_range(0, 1));
                v[k]  = 8'($urandom);
            end
            run_read("rand_read", n, en, v);
        end
    endtask

    task automatic test_random_writes();
        logic [7:0] pl[8];
        logic acks[9];
        logic [7:0] dat[8];
        logic [6:0] addr;
        logic match;
        int n, w0;
        for (int it = 0; it < 4; it++) begin
            n = $urandom_range(1, 4);
            match = 1'($urandom_range(0, 1));
            addr = 7'($urandom_range(0, 127));
            if (match) addr = 7'h49;
            else if (addr == 7'h49) addr = 7'h22;
            for (int k = 0; k < 8; k++) pl[k] = 8'($urandom);
            w0 = wok_cycles;
            master_write(addr, n, pl, acks, dat);
            send_stop();
            for (int k = 0; k <= n; k++) begin
                tests_run++;
                if (acks[k] !== !match) begin
                    tests_failed++; $display("FAIL rand_write addr %h ack[%0d]: got %b expected %b", addr, k, acks[k], !match);
                end
            end
            for (int k = 0; k < n; k++) begin
                tests_run++;
                if (dat[k] !== (match ? pl[k] : 8'hFF)) begin
                    tests_failed++; $display("FAIL rand_write addr %h data[%0d]: got %h expected %h", addr, k, dat[k], match ? pl[k] : 8'hFF);
                end
            end
            tests_run++;
            if (wok_cycles - w0 != (match ? n : 0)) begin
                tests_failed++; $display("FAIL rand_write writeOK: got %0d expected %0d", wok_cycles - w0, match ? n : 0);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_multi_write();
        test_addr_mismatch();
        test_read_single();
        test_read_two();
        test_reset_midway();
        test_random_reads();
        test_random_writes();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
